// File: rtl/halt_ctrl_pkg.sv
// Shared definitions for the MIX run/halt controller: FSM state encoding and halt-source indices.
package halt_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StStep  = 3'd2,
    StPause = 3'd3,
    StHalt  = 3'd4
  } state_e;

  localparam int unsigned SrcHlt    = 0;
  localparam int unsigned SrcFault  = 1;
  localparam int unsigned SrcOpstop = 2;
  localparam int unsigned SrcIo     = 3;

  // State entered when a go is accepted.
  function automatic state_e start_state(input logic step_mode);
    return step_mode ? StStep : StRun;
  endfunction

endpackage

// File: rtl/halt_ctrl_prio_enc.sv
// Combinational lowest-set-bit encoder; returns 0 when no bit is set.
module prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Run/halt controller for the MIX core: sticky halt causes, operator resume,
// single-step mode, and saturating retired-instruction / halt counters.
module halt_ctrl
  import halt_ctrl_pkg::*;
#(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  halt_req,
  input  logic             go,
  input  logic             step_mode,
  input  logic             instr_done,
  output logic             run,
  output logic             halted,
  output logic [NSRC-1:0]  cause,
  output logic [ID_W-1:0]  cause_id,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] halt_cnt
);

  state_e           state, state_nxt;
  logic [NSRC-1:0]  cause_nxt;
  logic [ID_W-1:0]  cause_id_nxt;
  logic             any_req;
  logic             enter_halt;

  assign any_req = |halt_req;

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause;
    enter_halt = 1'b0;
    unique case (state)
      StIdle: begin
        if (go) state_nxt = start_state(step_mode);
      end
      StRun: begin
        if (any_req) enter_halt = 1'b1;
      end
      StStep: begin
        if (any_req)         enter_halt = 1'b1;
        else if (instr_done) state_nxt  = StPause;
      end
      StPause: begin
        if (any_req) enter_halt = 1'b1;
        else if (go) state_nxt  = start_state(step_mode);
      end
      StHalt: begin
        // A go that coincides with a new request is dropped; the request still joins cause.
        if (go && !any_req) begin
          cause_nxt = '0;
          state_nxt = start_state(step_mode);
        end else begin
          cause_nxt = cause | halt_req;
        end
      end
      default: state_nxt = StIdle;
    endcase
    if (enter_halt) begin
      state_nxt = StHalt;
      cause_nxt = halt_req;
    end
  end

  // Encode the next cause so cause_id is registered alongside cause.
  prio_enc #(
    .N(NSRC),
    .W(ID_W)
  ) u_prio_enc (
    .req(cause_nxt),
    .idx(cause_id_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      run      <= 1'b0;
      halted   <= 1'b0;
      cause    <= '0;
      cause_id <= '0;
    end else begin
      state    <= state_nxt;
      run      <= (state_nxt == StRun) || (state_nxt == StStep);
      halted   <= (state_nxt == StHalt);
      cause    <= cause_nxt;
      cause_id <= cause_id_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
      halt_cnt  <= '0;
    end else begin
      if (instr_done && (instr_cnt != {CNT_W{1'b1}})) instr_cnt <= instr_cnt + 1'b1;
      if (enter_halt && (halt_cnt != {CNT_W{1'b1}}))  halt_cnt  <= halt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl: directed vector table, corner sequences, and
// randomized traffic against a behavioural model (a 4-bit-counter instance checks saturation).
module tb_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  halt_req = '0;
  logic        go = 1'b0;
  logic        step_mode = 1'b0;
  logic        instr_done = 1'b0;

  logic        run, halted;
  logic [3:0]  cause;
  logic [1:0]  cause_id;
  logic [15:0] instr_cnt, halt_cnt;

  logic        run4, halted4;
  logic [3:0]  cause4;
  logic [1:0]  cause_id4;
  logic [3:0]  instr_cnt4, halt_cnt4;

  halt_ctrl #(.NSRC(4), .CNT_W(16), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .go(go), .step_mode(step_mode),
    .instr_done(instr_done), .run(run), .halted(halted), .cause(cause),
    .cause_id(cause_id), .instr_cnt(instr_cnt), .halt_cnt(halt_cnt)
  );

  halt_ctrl #(.NSRC(4), .CNT_W(4), .ID_W(2)) dut4 (
    .clk(clk), .rst(rst), .halt_req(halt_req), .go(go), .step_mode(step_mode),
    .instr_done(instr_done), .run(run4), .halted(halted4), .cause(cause4),
    .cause_id(cause_id4), .instr_cnt(instr_cnt4), .halt_cnt(halt_cnt4)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int viol   = 0;

  // Behavioural model: flags rather than a state register.
  bit       m_started, m_run, m_halted, m_step;
  logic [3:0] m_cause;
  int       m_ic, m_hc;

  typedef struct {
    logic [3:0] req;
    logic       g, sm, d;
    logic       r, h;
    logic [3:0] c;
    logic [1:0] id;
    int         ic, hc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int lowest(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_started = 0; m_run = 0; m_halted = 0; m_step = 0;
    m_cause = '0; m_ic = 0; m_hc = 0;
  endtask

  task automatic model_step(input logic [3:0] req, input logic g, input logic sm,
                            input logic d);
    bit hr;
    hr = |req;
    if (d) begin
      if (!m_run) viol++;
      m_ic++;
    end
    if (!m_started) begin
      if (g) begin m_started = 1; m_run = 1; m_step = sm; end
    end else if (m_halted) begin
      if (g && !hr) begin
        m_halted = 0; m_cause = '0; m_run = 1; m_step = sm;
      end else begin
        m_cause |= req;
      end
    end else if (hr) begin
      m_halted = 1; m_run = 0; m_cause = req; m_hc++;
    end else if (m_run) begin
      if (m_step && d) m_run = 0;
    end else if (g) begin
      m_run = 1; m_step = sm;
    end
  endtask

  task automatic check_model();
    chk("run", run, m_run);
    chk("halted", halted, m_halted);
    chk("cause", cause, m_cause);
    chk("cause_id", cause_id, lowest(m_cause));
    chk("instr_cnt", instr_cnt, sat(m_ic, 16));
    chk("halt_cnt", halt_cnt, sat(m_hc, 16));
    chk("instr_cnt4", instr_cnt4, sat(m_ic, 4));
    chk("halt_cnt4", halt_cnt4, sat(m_hc, 4));
  endtask

  task automatic cycle(input logic [3:0] req, input logic g, input logic sm, input logic d);
    halt_req = req; go = g; step_mode = sm; instr_done = d;
    @(posedge clk);
    model_step(req, g, sm, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt_req = '0; go = 0; step_mode = 0; instr_done = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl.push_back('{4'b0000, 1, 0, 0, 1, 0, 4'b0000, 2'd0, 0, 0});
    tbl.push_back('{4'b0000, 0, 0, 1, 1, 0, 4'b0000, 2'd0, 1, 0});
    tbl.push_back('{4'b0000, 0, 0, 1, 1, 0, 4'b0000, 2'd0, 2, 0});
    tbl.push_back('{4'b0000, 0, 0, 1, 1, 0, 4'b0000, 2'd0, 3, 0});
    tbl.push_back('{4'b0001, 0, 0, 0, 0, 1, 4'b0001, 2'd0, 3, 1});
    tbl.push_back('{4'b1000, 0, 0, 0, 0, 1, 4'b1001, 2'd0, 3, 1});
    tbl.push_back('{4'b0000, 1, 0, 0, 1, 0, 4'b0000, 2'd0, 3, 1});
    tbl.push_back('{4'b0100, 0, 0, 0, 0, 1, 4'b0100, 2'd2, 3, 2});
    tbl.push_back('{4'b0000, 1, 1, 0, 1, 0, 4'b0000, 2'd0, 3, 2});
    tbl.push_back('{4'b0000, 0, 1, 1, 0, 0, 4'b0000, 2'd0, 4, 2});
    tbl.push_back('{4'b0000, 1, 1, 0, 1, 0, 4'b0000, 2'd0, 4, 2});
    tbl.push_back('{4'b0000, 0, 1, 1, 0, 0, 4'b0000, 2'd0, 5, 2});
    tbl.push_back('{4'b0010, 0, 0, 0, 0, 1, 4'b0010, 2'd1, 5, 3});
    tbl.push_back('{4'b1000, 1, 0, 0, 0, 1, 4'b1010, 2'd1, 5, 3});
    tbl.push_back('{4'b0010, 1, 0, 0, 0, 1, 4'b1010, 2'd1, 5, 3});
    tbl.push_back('{4'b0000, 1, 0, 0, 1, 0, 4'b0000, 2'd0, 5, 3});
    tbl.push_back('{4'b0001, 0, 0, 1, 0, 1, 4'b0001, 2'd0, 6, 4});
    tbl.push_back('{4'b0000, 0, 0, 0, 0, 1, 4'b0001, 2'd0, 6, 4});
    tbl.push_back('{4'b0000, 1, 1, 0, 1, 0, 4'b0000, 2'd0, 6, 4});
    tbl.push_back('{4'b0000, 0, 1, 1, 0, 0, 4'b0000, 2'd0, 7, 4});
    tbl.push_back('{4'b0100, 1, 0, 0, 0, 1, 4'b0100, 2'd2, 7, 5});
    tbl.push_back('{4'b0000, 1, 0, 0, 1, 0, 4'b0000, 2'd0, 7, 5});
    tbl.push_back('{4'b0000, 0, 1, 0, 1, 0, 4'b0000, 2'd0, 7, 5});
    tbl.push_back('{4'b0000, 0, 1, 1, 1, 0, 4'b0000, 2'd0, 8, 5});

    // Reset state and idle behaviour, including ignored halt_req.
    @(negedge clk);
    do_reset();
    repeat (5) cycle(4'b0000, 0, 0, 0);
    chk("rst_run", run, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", cause, 0);
    chk("rst_cause_id", cause_id, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
    chk("rst_halt_cnt", halt_cnt, 0);
    cycle(4'b1111, 0, 0, 0);
    chk("idle_req_halted", halted, 0);
    chk("idle_req_cause", cause, 0);
    chk("idle_req_halt_cnt", halt_cnt, 0);

    // Directed table.
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].req, tbl[i].g, tbl[i].sm, tbl[i].d);
      chk($sformatf("tbl%0d_run", i), run, tbl[i].r);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].h);
      chk($sformatf("tbl%0d_cause", i), cause, tbl[i].c);
      chk($sformatf("tbl%0d_cause_id", i), cause_id, tbl[i].id);
      chk($sformatf("tbl%0d_instr_cnt", i), instr_cnt, tbl[i].ic);
      chk($sformatf("tbl%0d_halt_cnt", i), halt_cnt, tbl[i].hc);
    end

    // Saturation on the narrow instance, then asynchronous reset mid-RUN.
    do_reset();
    cycle(4'b0000, 1, 0, 0);
    repeat (20) cycle(4'b0000, 0, 0, 1);
    chk("sat_instr_cnt4", instr_cnt4, 15);
    chk("sat_instr_cnt", instr_cnt, 20);
    chk("sat_run_before_rst", run, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_run", run, 0);
    chk("async_halted", halted, 0);
    chk("async_instr_cnt", instr_cnt, 0);
    chk("async_instr_cnt4", instr_cnt4, 0);
    chk("async_cause", cause, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] req;
      logic g, sm, d;
      if ($urandom_range(0, 499) == 0) do_reset();
      req = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      g   = ($urandom_range(0, 4) == 0);
      sm  = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 2) == 0);
      cycle(req, g, sm, d);
      check_model();
    end

    $display("info: %0d instr_done pulses arrived while run=0 (protocol violation)", viol);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
